// File: rtl/sync_filter.sv
// Multi-channel synchronizer: per-channel flop chain, reset value, edge pulses.
// Define SYNC_FILTER_EN to add a per-channel glitch-rejection filter on q.
module sync_filter_lane #(
    parameter int   STAGES        = 2,
`ifdef SYNC_FILTER_EN
    parameter int   FILTER_CYCLES = 4,
`endif
    parameter logic RST           = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] s;
    logic              sync;
    logic              q_prev;

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) s <= {STAGES{RST}};
        else         s <= {s[STAGES-2:0], d};
    end

    assign sync = s[STAGES-1];

`ifdef SYNC_FILTER_EN
    localparam int             CW   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0]  TERM = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          q_r;

    // q only follows sync once it has disagreed for FILTER_CYCLES edges in a row.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_r <= RST;
            cnt <= '0;
        end else if (sync != q_r) begin
            if (cnt == TERM) begin
                q_r <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign q = q_r;
`else
    assign q = sync;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) q_prev <= RST;
        else         q_prev <= q;
    end

    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;
endmodule

module sync_filter #(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
`ifdef SYNC_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("sync_filter: STAGES must be in 2..4");
        end
        if (FILTER_EN && (FILTER_CYCLES < 1 || FILTER_CYCLES > 255)) begin : g_bad_filter
            $error("sync_filter: FILTER_CYCLES must be in 1..255");
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            sync_filter_lane #(
                .STAGES        (STAGES),
`ifdef SYNC_FILTER_EN
                .FILTER_CYCLES (FILTER_CYCLES),
`endif
                .RST           (RESET_VAL[i])
            ) u_lane (
                .clk    (clk),
                .resetn (resetn),
                .d      (d[i]),
                .q      (q[i]),
                .rise   (rise[i]),
                .fall   (fall[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_sync_filter.sv
// Scoreboard bench for sync_filter: stimulus queues expected pulses/levels, a monitor checks them.
module tb_sync_filter;
    localparam int             W   = 4;
    localparam int             ST  = 3;
    localparam int             FC  = 4;
    localparam logic [W-1:0]   RV  = 4'b1010;
`ifdef SYNC_FILTER_EN
    localparam int             LAT  = ST + FC;
    localparam bit             FILT = 1'b1;
`else
    localparam int             LAT  = ST;
    localparam bit             FILT = 1'b0;
`endif

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic [W-1:0] d      = 4'b0101;
    logic [W-1:0] q, rise, fall;

    sync_filter #(
        .WIDTH         (W),
        .STAGES        (ST),
        .RESET_VAL     (RV),
        .FILTER_CYCLES (FC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .d      (d),
        .q      (q),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int ch; bit up; } pulse_t;
    typedef struct { int cyc; logic [W-1:0] mask; logic [W-1:0] val; } lvl_t;

    pulse_t       pq[$];
    lvl_t         lq[$];
    logic [W-1:0] model_q;
    int           checks = 0;
    int           errors = 0;
    bit           done   = 1'b0;

    task automatic exp_pulse(input int c, input int ch, input bit up);
        pulse_t p;
        p.cyc = c; p.ch = ch; p.up = up;
        pq.push_back(p);
    endtask

    task automatic exp_lvl(input int c, input logic [W-1:0] m, input logic [W-1:0] v);
        lvl_t l;
        l.cyc = c; l.mask = m; l.val = v & m;
        lq.push_back(l);
    endtask

    task automatic release_reset();
        int c;
        resetn = 1'b1;
        c = cyc;
        exp_lvl(c + 1, '1, RV);
        exp_lvl(c + LAT - 1, '1, RV);
        exp_lvl(c + LAT, '1, d);
        for (int i = 0; i < W; i++)
            if (RV[i] != d[i]) exp_pulse(c + LAT, i, d[i]);
        model_q = d;
    endtask

    task automatic set_ch(input int ch, input logic v);
        int c;
        logic [W-1:0] m;
        c = cyc;
        m = '0; m[ch] = 1'b1;
        d[ch] = v;
        exp_lvl(c + LAT - 1, m, {W{model_q[ch]}});
        exp_lvl(c + LAT, m, {W{v}});
        exp_pulse(c + LAT, ch, v);
        model_q[ch] = v;
    endtask

    task automatic glitch(input int ch, input int len);
        int c;
        logic old;
        logic [W-1:0] m;
        c = cyc;
        m = '0; m[ch] = 1'b1;
        old = model_q[ch];
        if (FILT && len < FC) begin
            exp_lvl(c + LAT, m, {W{old}});
            exp_lvl(c + len + LAT, m, {W{old}});
        end else begin
            exp_pulse(c + LAT, ch, ~old);
            exp_pulse(c + len + LAT, ch, old);
            exp_lvl(c + LAT, m, {W{~old}});
            exp_lvl(c + len + LAT - 1, m, {W{~old}});
            exp_lvl(c + len + LAT, m, {W{old}});
        end
        d[ch] = ~old;
        repeat (len) @(negedge clk);
        d[ch] = old;
    endtask

    task automatic settle();
        repeat (LAT + 2) @(negedge clk);
        exp_lvl(cyc + 1, '1, model_q);
        @(negedge clk);
    endtask

    initial begin
        int p;
        model_q = RV;
        exp_lvl(2, '1, RV);
        repeat (3) @(negedge clk);
        release_reset();
        settle();

        // short reset pulse entirely between edges: only an async reset is seen
        @(posedge clk);
        #1 resetn = 1'b0;
        #3 exp_lvl(cyc, '1, RV);
        release_reset();
        settle();

        set_ch(0, 1'b0); settle();
        set_ch(0, 1'b1); settle();
        set_ch(3, 1'b1); set_ch(2, 1'b0); settle();

        glitch(1, 3); settle();
        glitch(1, 6); settle();
        glitch(3, 1); settle();

        p = FILT ? FC : 2;
        for (int k = 0; k < 6; k++) begin
            set_ch(0, ~model_q[0]);
            repeat (p) @(negedge clk);
        end
        settle();
        done = 1'b1;
    end

    always @(negedge clk) begin
        bit found;
        for (int ch = 0; ch < W; ch++) begin
            for (int u = 0; u < 2; u++) begin
                if ((u == 1) ? rise[ch] : fall[ch]) begin
                    found = 1'b0;
                    checks++;
                    for (int i = pq.size() - 1; i >= 0; i--) begin
                        if (!found && pq[i].cyc == cyc && pq[i].ch == ch && pq[i].up == (u == 1)) begin
                            pq.delete(i);
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        errors++;
                        $display("FAIL pulse_unexpected cyc=%0d ch=%0d %s (no such pulse expected)",
                                 cyc, ch, (u == 1) ? "rise" : "fall");
                    end
                end
            end
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL pulse_missing cyc=%0d ch=%0d %s: got none, required at cyc %0d",
                         cyc, pq[i].ch, pq[i].up ? "rise" : "fall", pq[i].cyc);
                pq.delete(i);
            end
        end
        for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].cyc <= cyc) begin
                checks++;
                if (lq[i].cyc != cyc || (q & lq[i].mask) !== lq[i].val) begin
                    errors++;
                    $display("FAIL level cyc=%0d q=%b mask=%b required=%b (for cyc %0d)",
                             cyc, q, lq[i].mask, lq[i].val, lq[i].cyc);
                end
                lq.delete(i);
            end
        end
        if (done) begin
            checks++;
            if (pq.size() != 0 || lq.size() != 0) begin
                errors++;
                $display("FAIL leftover pending pulses=%0d levels=%0d required 0", pq.size(), lq.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout at cyc=%0d: stimulus did not complete", cyc);
        $fatal(1, "timeout");
    end
endmodule
